// File: rtl/gda_vl_pkg.sv
// gda_vl_pkg: shared types and elaboration-time helpers for the GDA adder.
//   state_t     - controller states (IDLE, HOLD, CORR)
//   num_blocks  - number of M-bit sub-adder blocks in an N-bit operand
//   win_lo      - low bit index of block k's carry-prediction window
package gda_vl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    CORR = 2'd2
  } state_t;

  function automatic int num_blocks(input int n, input int m);
    return n / m;
  endfunction

  // Window for block k covers bits [k*m-1 : max(k*m-p, 0)].
  function automatic int win_lo(input int k, input int m, input int p);
    return (k * m > p) ? (k * m - p) : 0;
  endfunction

endpackage

// File: rtl/gda_carry_pred.sv
// gda_carry_pred: carry predictor for one GDA block window.
// The predicted carry is the window's carry-out with its bottom carry-in
// forced to 0; the prediction is wrong exactly when the whole window
// propagates and the true carry into the window bottom is 1.
// Ports:
//   g_i     [W-1:0] generate bits of the window (a & b)
//   p_i     [W-1:0] propagate bits of the window (a ^ b)
//   cin_i           true carry into the window's bottom bit
//   cpred_o         predicted carry into the block above the window
//   err_o           prediction differs from the true carry
module gda_carry_pred
  import gda_vl_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] g_i,
  input  logic [W-1:0] p_i,
  input  logic         cin_i,
  output logic         cpred_o,
  output logic         err_o
);

  if (W < 1) begin : g_bad_w
    $error("gda_carry_pred: W must be >= 1");
  end

  always_comb begin
    cpred_o = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      cpred_o = g_i[i] | (p_i[i] & cpred_o);
    end
  end

  assign err_o = (&p_i) & cin_i;

endmodule

// File: rtl/gda_vl_adder.sv
// gda_vl_adder: pipelined Generic Dual-Approximate adder with error detection.
// Operands are split into N/M exact ripple blocks whose carry-ins are
// predicted from a P-bit window below each block. Errors are flagged; when
// GDA_ERR_CORR_EN is defined, an errored result spends one extra cycle in
// CORR where the exact sum replaces the approximate one.
// Build option: GDA_ERR_CORR_EN (undefined by default = no correction).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake
//   in_a, in_b  [N-1:0]   unsigned operands
//   out_valid/out_ready   result handshake
//   out_sum     [N:0]     sum with carry-out at MSB
//   out_err               approximate sum differed from the exact sum
//   out_corr              out_sum holds the corrected exact sum
module gda_vl_adder
  import gda_vl_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 2,
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_sum,
  output logic         out_err,
  output logic         out_corr
);

  if (N < 2 || M < 1 || (N % M) != 0 || P < 1 || P > N - M) begin : g_bad_params
    $error("gda_vl_adder: illegal parameters (need N>=2, N%%M==0, 1<=P<=N-M)");
  end

  localparam int NB    = num_blocks(N, M);
  // Highest window bottom index; the true-carry chain only needs to reach it.
  localparam int LOMAX = win_lo(NB - 1, M, P);

  // ---------------------------------------------------------------------------
  // Approximate datapath
  // ---------------------------------------------------------------------------
  logic [N-1:0]   g, p;
  logic [LOMAX:0] tc;        // true carry into bit i
  logic [NB-1:0]  cin_blk;   // predicted carry-in per block
  logic [NB-1:0]  err_blk;
  logic [N:0]     approx;
  logic           err_now;

  assign g = in_a & in_b;
  assign p = in_a ^ in_b;

  always_comb begin
    tc = '0;
    for (int unsigned i = 0; i < LOMAX; i++) begin
      tc[i+1] = g[i] | (p[i] & tc[i]);
    end
  end

  assign cin_blk[0] = 1'b0;
  assign err_blk[0] = 1'b0;

  for (genvar k = 1; k < NB; k++) begin : g_pred
    localparam int LO = win_lo(k, M, P);
    localparam int HI = k * M - 1;
    gda_carry_pred #(.W(HI - LO + 1)) u_pred (
      .g_i    (g[HI:LO]),
      .p_i    (p[HI:LO]),
      .cin_i  (tc[LO]),
      .cpred_o(cin_blk[k]),
      .err_o  (err_blk[k])
    );
  end

  assign err_now = |err_blk;

  // Each block ripples from its predicted carry-in; the final carry left in
  // c after the last block is the top block's carry-out.
  always_comb begin
    logic c;
    c      = 1'b0;
    approx = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      c = cin_blk[k];
      for (int unsigned j = 0; j < M; j++) begin
        approx[k*M + j] = p[k*M + j] ^ c;
        c               = g[k*M + j] | (p[k*M + j] & c);
      end
    end
    approx[N] = c;
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
`ifdef GDA_ERR_CORR_EN
          state_d = err_now ? CORR : HOLD;
`else
          state_d = HOLD;
`endif
        end else if (state_q == HOLD && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef GDA_ERR_CORR_EN
      CORR:    state_d = HOLD;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
    out_valid = (state_q == HOLD);
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  logic [N:0] sum_q, sum_d;
  logic       err_q, err_d;
  logic       corr_q, corr_d;
`ifdef GDA_ERR_CORR_EN
  logic [N-1:0] a_q, a_d, b_q, b_d;

  assign a_d = accept ? in_a : a_q;
  assign b_d = accept ? in_b : b_q;
`endif

  always_comb begin
    sum_d  = sum_q;
    err_d  = err_q;
    corr_d = corr_q;
    if (accept) begin
      sum_d  = approx;
      err_d  = err_now;
      corr_d = 1'b0;
    end
`ifdef GDA_ERR_CORR_EN
    else if (state_q == CORR) begin
      sum_d  = {1'b0, a_q} + {1'b0, b_q};
      corr_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      err_q  <= 1'b0;
      corr_q <= 1'b0;
`ifdef GDA_ERR_CORR_EN
      a_q    <= '0;
      b_q    <= '0;
`endif
    end else begin
      sum_q  <= sum_d;
      err_q  <= err_d;
      corr_q <= corr_d;
`ifdef GDA_ERR_CORR_EN
      a_q    <= a_d;
      b_q    <= b_d;
`endif
    end
  end

  assign out_sum  = sum_q;
  assign out_err  = err_q;
  assign out_corr = corr_q;

endmodule

// File: tb/tb_gda_vl_adder.sv
// tb_gda_vl_adder: self-checking bench for gda_vl_adder.
// Instance d8 (N=8,M=2,P=2) runs a vector table and handshake corner cases;
// instance d16 (N=16,M=4,P=4) runs a random sweep against a window model.
// Expectations follow whichever GDA_ERR_CORR_EN setting the bench is built with.
module tb_gda_vl_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8, err8, corr8;
  logic [7:0]  a8, b8;
  logic [8:0]  sum8;
  logic        iv16, ir16, ov16, or16, err16, corr16;
  logic [15:0] a16, b16;
  logic [16:0] sum16;

  gda_vl_adder #(.N(8), .M(2), .P(2)) d8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(or8),
    .out_sum(sum8), .out_err(err8), .out_corr(corr8)
  );

  gda_vl_adder #(.N(16), .M(4), .P(4)) d16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .out_valid(ov16), .out_ready(or16),
    .out_sum(sum16), .out_err(err16), .out_corr(corr16)
  );

  typedef struct {
    logic [16:0] sum;
    logic        err;
    logic        corr;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] approx;
    logic [8:0] exact;
  } vec_t;

  exp_t q8[$];
  exp_t q16[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

`ifdef GDA_ERR_CORR_EN
  localparam bit CORR_ON = 1'b1;
`else
  localparam bit CORR_ON = 1'b0;
`endif

  function automatic exp_t mk8(input logic [8:0] approx, input logic [8:0] exact);
    exp_t e;
    e.err  = (approx != exact);
    e.corr = CORR_ON && e.err;
    e.sum  = {8'd0, (e.corr ? exact : approx)};
    return e;
  endfunction

  // Golden GDA model: per-block carry from the arithmetic carry-out of the
  // window slice, block sums assembled arithmetically.
  function automatic void gold(input int n, input int m, input int p, input int a, input int b,
                               output int approx, output bit err);
    int mm, cin, s, lo, w;
    mm     = (1 << m) - 1;
    approx = 0;
    for (int k = 0; k < n / m; k++) begin
      if (k == 0) cin = 0;
      else begin
        lo  = (k * m > p) ? k * m - p : 0;
        w   = k * m - lo;
        cin = (((a >> lo) & ((1 << w) - 1)) + ((b >> lo) & ((1 << w) - 1))) >> w;
      end
      s = ((a >> (k * m)) & mm) + ((b >> (k * m)) & mm) + cin;
      approx |= (s & mm) << (k * m);
      if (k == n / m - 1) approx |= (s >> m) << n;
    end
    err = (approx != a + b);
  endfunction

  // ---------------- drivers ----------------
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    iv8 = 1'b1; a8 = a; b8 = b;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (ir8) break;
      if (t == 20) begin chk("send8_accept", 32'(ir8), 32'd1); iv8 = 1'b0; return; end
    end
    q8.push_back(e);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    iv16 = 1'b1; a16 = a; b16 = b;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (ir16) break;
      if (t == 40) begin chk("send16_accept", 32'(ir16), 32'd1); iv16 = 1'b0; return; end
    end
    q16.push_back(e);
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic drain(input int which);
    for (int t = 0; t < 40; t++) begin
      if ((which == 8 ? q8.size() : q16.size()) == 0) break;
      @(posedge clk); #1;
    end
    if (which == 8) chk("drain8", 32'(q8.size()), 32'd0);
    else            chk("drain16", 32'(q16.size()), 32'd0);
  endtask

  // ---------------- monitors ----------------
  exp_t        m8e, m16e;
  logic        hold8_prev = 1'b0, hold16_prev = 1'b0;
  logic [10:0] hold8_snap;
  logic [18:0] hold16_snap;

  always @(negedge clk) begin
    if (!rst_n) hold8_prev = 1'b0;
    else begin
      if (hold8_prev) begin
        chk("hold8_valid", 32'(ov8), 32'd1);
        chk("hold8_stable", 32'({sum8, err8, corr8}), 32'(hold8_snap));
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) chk("out8_unexpected", 32'(ov8), 32'd0);
        else begin
          m8e = q8.pop_front();
          chk("out8_sum", 32'(sum8), 32'(m8e.sum));
          chk("out8_err", 32'(err8), 32'(m8e.err));
          chk("out8_corr", 32'(corr8), 32'(m8e.corr));
        end
      end
      hold8_prev = ov8 && !or8;
      hold8_snap = {sum8, err8, corr8};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) hold16_prev = 1'b0;
    else begin
      if (hold16_prev) begin
        chk("hold16_valid", 32'(ov16), 32'd1);
        chk("hold16_stable", 32'({sum16, err16, corr16}), 32'(hold16_snap));
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) chk("out16_unexpected", 32'(ov16), 32'd0);
        else begin
          m16e = q16.pop_front();
          chk("out16_sum", 32'(sum16), 32'(m16e.sum));
          chk("out16_err", 32'(err16), 32'(m16e.err));
          chk("out16_corr", 32'(corr16), 32'(m16e.corr));
        end
      end
      hold16_prev = ov16 && !or16;
      hold16_snap = {sum16, err16, corr16};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  vec_t tbl[12];
  logic sweep_done = 1'b0;

  initial begin
    tbl[0]  = '{8'h12, 8'h21, 9'h033, 9'h033};
    tbl[1]  = '{8'h0F, 8'h01, 9'h000, 9'h010};
    tbl[2]  = '{8'hFF, 8'h01, 9'h0F0, 9'h100};
    tbl[3]  = '{8'h01, 8'h01, 9'h002, 9'h002};
    tbl[4]  = '{8'h03, 8'h04, 9'h007, 9'h007};
    tbl[5]  = '{8'h80, 8'h80, 9'h100, 9'h100};
    tbl[6]  = '{8'h3C, 8'h04, 9'h000, 9'h040};
    tbl[7]  = '{8'hAA, 8'h55, 9'h0FF, 9'h0FF};
    tbl[8]  = '{8'hFF, 8'hFF, 9'h1FE, 9'h1FE};
    tbl[9]  = '{8'h00, 8'h00, 9'h000, 9'h000};
    tbl[10] = '{8'h0C, 8'h04, 9'h010, 9'h010};
    tbl[11] = '{8'h30, 8'h10, 9'h040, 9'h040};

    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(ov8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_err", 32'(err8), 32'd0);
    chk("rst_corr", 32'(corr8), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(ir8), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Table vectors with latency checks, out_ready held high
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      e = mk8(tbl[i].approx, tbl[i].exact);
      send8(tbl[i].a, tbl[i].b, e);
      if (CORR_ON && e.err) begin
        chk("lat2_bubble_valid", 32'(ov8), 32'd0);
        chk("corr_in_ready", 32'(ir8), 32'd0);
        @(posedge clk); #1;
      end
      chk("lat_valid", 32'(ov8), 32'd1);
    end
    drain(8);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back with 3 cycles of backpressure
    or8 = 1'b0;
    fork
      begin
        send8(8'hFF, 8'h01, mk8(9'h0F0, 9'h100));
        send8(8'h01, 8'h01, mk8(9'h002, 9'h002));
      end
      begin
        @(posedge clk); #1;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(ir8), 32'd0);
        end
        chk("bp_valid", 32'(ov8), 32'd1);
        chk("bp_sum", 32'(sum8), CORR_ON ? 32'h100 : 32'h0F0);
        @(posedge clk); #1;
        or8 = 1'b1;
      end
    join
    drain(8);
    repeat (2) @(posedge clk);
    #1;

    // Reset while the errored operation is in flight
    send8(8'h0F, 8'h01, mk8(9'h000, 9'h010));
    #1 rst_n = 1'b0;
    q8.delete();
    #1;
    chk("midrst_valid", 32'(ov8), 32'd0);
    chk("midrst_sum", 32'(sum8), 32'd0);
    chk("midrst_err", 32'(err8), 32'd0);
    chk("midrst_corr", 32'(corr8), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("midrst_in_ready", 32'(ir8), 32'd1);
    @(posedge clk); #1;
    send8(8'h03, 8'h04, mk8(9'h007, 9'h007));
    drain(8);

    // Random sweep on the 16-bit instance with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [15:0] a, b;
          int          ap;
          bit          er;
          exp_t        e;
          a = 16'($urandom);
          if (i % 2 == 0) b = 16'($urandom);
          else b = (~a & 16'hFFF0) | 16'($urandom_range(0, 15));
          gold(16, 4, 4, int'(a), int'(b), ap, er);
          e.err  = er;
          e.corr = CORR_ON && er;
          e.sum  = CORR_ON ? ({1'b0, a} + {1'b0, b}) : 17'(ap);
          send16(a, b, e);
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk); #1;
          or16 = ($urandom_range(0, 3) != 0);
        end
        or16 = 1'b1;
      end
    join
    drain(16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
